// File: rtl/opposite_serial.sv
// Digit-serial two's-complement pass/negate/abs unit: DIGIT bits per cycle, LSB first,
// with a start/ready handshake, a one-cycle done pulse and most-negative overflow flagging.
module opposite_serial #(
  parameter int WORDSIZE = 64,
  parameter int DIGIT    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [WORDSIZE-1:0] num_input,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [WORDSIZE-1:0] num_output,
  output logic                overflow
);

  localparam int N     = WORDSIZE / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [WORDSIZE-1:0] MOST_NEG = {1'b1, {(WORDSIZE-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                carry_q, carry_d;
  logic                neg_q, neg_d;
  logic [WORDSIZE-1:0] operand_q, operand_d;
  logic [WORDSIZE-1:0] result_q, result_d;
  logic [WORDSIZE-1:0] num_output_q, num_output_d;
  logic                overflow_q, overflow_d;

  logic [DIGIT-1:0]    digit;
  logic [DIGIT:0]      step;

  // One digit of the negation ripple: {carry_out, result_digit}; pass-through keeps the carry.
  function automatic logic [DIGIT:0] digit_step(input logic [DIGIT-1:0] d,
                                                 input logic neg, input logic cin);
    if (neg) return {1'b0, ~d} + {{DIGIT{1'b0}}, cin};
    else     return {cin, d};
  endfunction

  assign digit = operand_q[int'(cnt_q)*DIGIT +: DIGIT];
  assign step  = digit_step(digit, neg_q, carry_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    carry_d      = carry_q;
    neg_d        = neg_q;
    operand_d    = operand_q;
    result_d     = result_q;
    num_output_d = num_output_q;
    overflow_d   = overflow_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          operand_d = num_input;
          neg_d     = (mode == 2'b01) || ((mode == 2'b10) && num_input[WORDSIZE-1]);
          carry_d   = neg_d;
          cnt_d     = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        result_d[int'(cnt_q)*DIGIT +: DIGIT] = step[DIGIT-1:0];
        carry_d = step[DIGIT];
        if (cnt_q == CNT_W'(N-1)) begin
          // Publish only the finished word; the final carry-out is dropped.
          num_output_d = result_d;
          overflow_d   = neg_q && (operand_q == MOST_NEG);
          cnt_d        = '0;
          state_d      = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      num_output_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      num_output_q <= num_output_d;
      overflow_q   <= overflow_d;
    end
  end

  // Working operand/result/carry are only meaningful after an accepted start.
  always_ff @(posedge clk) begin
    carry_q   <= carry_d;
    neg_q     <= neg_d;
    operand_q <= operand_d;
    result_q  <= result_d;
  end

  assign ready      = (state_q == S_IDLE);
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign num_output = num_output_q;
  assign overflow   = overflow_q;

endmodule
